// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sram_arb_pkg;

    // Arbiter FSM: idle, or one access in flight waiting for its response
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    // Owner encoding, also used as the round-robin pointer value
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Bit positions inside the {data, inst} request / grant vectors
    localparam int GNT_INST = 0;
    localparam int GNT_DATA = 1;

    // Default SRAM read latency in cycles (legal 1..3)
    localparam int RD_LATENCY_DEF = 1;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection between instruction and data requesters, one-hot grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant is only a choice, the caller decides if a slot exists.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [1:0] i_reqs,  // {data_req, inst_req}
    input  logic       i_ptr,   // owner granted last
    output logic [1:0] o_gnt    // one-hot {data, inst}
);

`ifndef SRAM_ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for the pointer
    logic w_unused_ptr;
    assign w_unused_ptr = i_ptr;
`endif

    // Single requester wins outright; a conflict is resolved by the policy
    always_comb begin
        o_gnt = 2'b00;
        if (i_reqs[GNT_DATA] && i_reqs[GNT_INST]) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            if (i_ptr == OWN_DATA) begin
                o_gnt[GNT_INST] = 1'b1;
            end else begin
                o_gnt[GNT_DATA] = 1'b1;
            end
`else
            o_gnt[GNT_DATA] = 1'b1;
`endif
        end else begin
            o_gnt = i_reqs;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates inst/data requesters onto one single-port SRAM, one access in flight.
// Latency: addr_ok combinational with request; data_ok exactly RD_LATENCY cycles later.
// Backpressure: requests stall (no addr_ok) while busy; responses are never stalled.
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN for alternating conflict resolution.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    // instruction requester
    input  logic                    inst_req,
    input  logic                    inst_wr,
    input  logic [DATA_WIDTH/8-1:0] inst_wstrb,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    input  logic [DATA_WIDTH-1:0]   inst_wdata,
    output logic                    inst_addr_ok,
    output logic                    inst_data_ok,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    // data requester
    input  logic                    data_req,
    input  logic                    data_wr,
    input  logic [DATA_WIDTH/8-1:0] data_wstrb,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic                    data_addr_ok,
    output logic                    data_data_ok,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    // single-port SRAM
    output logic                    sram_en,
    output logic [DATA_WIDTH/8-1:0] sram_we,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata
);

    localparam logic [1:0] LAT_CNT = 2'(RD_LATENCY);

    arb_state_t r_state;
    logic [1:0] r_cnt;
    logic       r_owner;

    logic       w_resp;
    logic       w_slot;
    logic [1:0] w_reqs;
    logic [1:0] w_pick;
    logic [1:0] w_gnt;
    logic       w_grant;
    logic       w_win_own;
    logic       w_ptr;

    // Response cycle is the last count of the in-flight access
    assign w_resp  = (r_state == ST_WAIT) && (r_cnt == 2'd1);
    // A new access may start when idle or as the current one completes;
    // reset also blocks grants so every output reads zero while it is held
    assign w_slot  = !reset && ((r_state == ST_IDLE) || w_resp);
    assign w_reqs  = {data_req, inst_req};
    assign w_gnt   = w_slot ? w_pick : 2'b00;
    assign w_grant = |w_gnt;
    assign w_win_own = w_gnt[GNT_DATA] ? OWN_DATA : OWN_INST;

    sram_arb_pick u_pick (
        .i_reqs (w_reqs),
        .i_ptr  (w_ptr),
        .o_gnt  (w_pick)
    );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic r_ptr;

    // Remember the last winner so the other side takes the next conflict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= OWN_INST;
        end else if (w_grant) begin
            r_ptr <= w_win_own;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = OWN_INST;
`endif

    assign inst_addr_ok = w_gnt[GNT_INST];
    assign data_addr_ok = w_gnt[GNT_DATA];
    assign sram_en      = w_grant;

    // Steer the winner's command onto the SRAM; idle bus is all zeros
    always_comb begin
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_gnt[GNT_DATA]) begin
            sram_we    = data_wr ? data_wstrb : '0;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (w_gnt[GNT_INST]) begin
            sram_we    = inst_wr ? inst_wstrb : '0;
            sram_addr  = inst_addr;
            sram_wdata = inst_wdata;
        end
    end

    // Writes complete with the same timing as reads, so both return data_ok
    assign inst_data_ok = w_resp && (r_owner == OWN_INST);
    assign data_data_ok = w_resp && (r_owner == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? sram_rdata : '0;
    assign data_rdata   = data_data_ok ? sram_rdata : '0;

    // Track the in-flight access; a grant on the response cycle chains back-to-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_owner <= OWN_INST;
        end else if (w_grant) begin
            r_state <= ST_WAIT;
            r_cnt   <= LAT_CNT;
            r_owner <= w_win_own;
        end else if (r_state == ST_WAIT) begin
            if (w_resp) begin
                r_state <= ST_IDLE;
                r_cnt   <= 2'd0;
            end else begin
                r_cnt   <= r_cnt - 2'd1;
            end
        end
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width of both requesters and the SRAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of data words; wstrb width is DATA_WIDTH/8.
REQ-003 SHALL have parameter RD_LATENCY, default 1, SRAM cycles from sram_en to valid sram_rdata; legal range 1..3.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous reset, active-high.
REQ-007 SHALL have ports inst_req / data_req  in  1  request pending, held until addr_ok.
REQ-008 SHALL have ports inst_wr / data_wr  in  1  1=write, 0=read.
REQ-009 SHALL have ports inst_wstrb / data_wstrb  in  DATA_WIDTH/8  byte write enables.
REQ-010 SHALL have ports inst_addr / data_addr  in  ADDR_WIDTH  request address.
REQ-011 SHALL have ports inst_wdata / data_wdata  in  DATA_WIDTH  write data.
REQ-012 SHALL have ports inst_addr_ok / data_addr_ok  out  1  request accepted this cycle.
REQ-013 SHALL have ports inst_data_ok / data_data_ok  out  1  response valid this cycle.
REQ-014 SHALL have ports inst_rdata / data_rdata  out  DATA_WIDTH  read data, 0 unless matching data_ok.
REQ-015 SHALL have ports sram_en  out  1, sram_we  out  DATA_WIDTH/8, sram_addr  out  ADDR_WIDTH, sram_wdata  out  DATA_WIDTH, sram_rdata  in  DATA_WIDTH  single-port SRAM.

Function
REQ-016 SHALL implement FSM states IDLE and WAIT with a response counter cnt and owner register (INST/DATA).
REQ-017 SHALL grant at most one request per cycle: in IDLE, or in WAIT on the data_ok cycle, when any req is high.
REQ-018 On grant SHALL assert the winner's addr_ok, sram_en=1, sram_we=wr?wstrb:0, sram_addr/sram_wdata from winner, combinationally in the same cycle.
REQ-019 Without grant SHALL drive sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
REQ-020 On grant SHALL load cnt=RD_LATENCY, latch owner, enter WAIT.
REQ-021 In WAIT SHALL decrement cnt each cycle; when cnt==1 SHALL assert owner's data_ok for one cycle with rdata=sram_rdata, for reads and writes alike.
REQ-022 data_ok SHALL occur exactly RD_LATENCY cycles after the addr_ok cycle; at most one request outstanding.
REQ-023 On the data_ok cycle: with a new grant SHALL reload cnt and stay WAIT (back-to-back, one transfer per cycle when RD_LATENCY=1); otherwise SHALL return to IDLE.
REQ-024 With both req high, data requester SHALL win (fixed priority) unless ROUND_ROBIN_EN is defined.
REQ-025 A request SHALL remain eligible every cycle until granted; responses SHALL not be back-pressured.

Reset
REQ-026 While reset is high SHALL force IDLE, cnt=0, owner=INST, rr pointer=INST, and all outputs 0 including addr_ok.
REQ-027 Reset mid-WAIT SHALL discard the outstanding response; no data_ok SHALL appear after reset deasserts until a new grant.

Configuration
REQ-028 With SRAM_ARB_ROUND_ROBIN_EN defined, on conflict SHALL grant the requester not granted last (pointer updated on every grant); first conflict after reset grants data.
REQ-029 Without SRAM_ARB_ROUND_ROBIN_EN, SHALL use fixed data-over-inst priority and contain no pointer register.

Structure
REQ-030 Package sram_arb_pkg SHALL hold the FSM state enum, owner encoding (OWN_INST, OWN_DATA) and RD_LATENCY default.
REQ-031 Winner selection SHALL be sub-module sram_arb_pick (combinational; inputs reqs and pointer, output one-hot grant).

Verification
REQ-032 Single read, RD_LATENCY=1: data_req=1, data_wr=0, addr=0x100, SRAM returns 0xDEADBEEF -> data_addr_ok cycle 0, data_data_ok cycle 1, data_rdata=0xDEADBEEF.
REQ-033 Write: inst_req, inst_wr=1, wstrb=0x3, addr=0x40, wdata=0x12345678 -> sram_we=0x3, sram_addr=0x40 cycle 0, inst_data_ok cycle 1.
REQ-034 Conflict, fixed priority: both req held 3 cycles -> grants data,data,data; inst waits; with ROUND_ROBIN_EN -> data,inst,data.
REQ-035 RD_LATENCY=3: data read at cycle 0 with inst_req at cycle 1 -> inst_addr_ok not before cycle 3; data_data_ok at cycle 3; inst_data_ok at cycle 6.
REQ-036 Reset pulse at cycle 1 of RD_LATENCY=3 read -> no data_ok in cycles 2..6; all outputs 0 during reset.
